// File: rtl/dp_pkg.sv
// dp_pkg: opcode constants and FSM state type shared by the datapath files
package dp_pkg;
    localparam logic [2:0] OP_LDI = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_ADC = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;
    typedef enum logic {IDLE, MUL} state_t;
endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational single-cycle ALU (LDI, logic ops, add/adc/sub with carry-out)
module dp_alu
    import dp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             co,
    output logic             cv
);
    logic [WIDTH:0] sum;
    // one shared adder; SUB is A + ~B + 1 so carry-out means no borrow
    always_comb begin
        sum = {1'b0, a} + {1'b0, (op == OP_SUB) ? ~b : b}
            + {{WIDTH{1'b0}}, (op == OP_SUB) ? 1'b1 : (op == OP_ADC) ? cin : 1'b0};
        y   = (op == OP_LDI) ? imm :
              (op == OP_OR)  ? (a | b) :
              (op == OP_AND) ? (a & b) :
              (op == OP_XOR) ? (a ^ b) : sum[WIDTH-1:0];
        co  = sum[WIDTH];
        cv  = (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB);
    end
endmodule

// File: rtl/datapath_core.sv
// datapath_core: register file + ALU datapath with command handshake and shift-add multiplier
module datapath_core
    import dp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             ck,
    input  logic             clr_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_dst,
    input  logic [AW-1:0]    cmd_sa,
    input  logic [AW-1:0]    cmd_sb,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             flag_c,
    output logic             flag_z,
    input  logic [AW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);
    localparam int CW = $clog2(WIDTH + 1);
    logic [WIDTH-1:0] rf [NREGS];
    logic [WIDTH-1:0] op_a, op_b, alu_y, ma, mb, acc, acc_nx;
    logic             alu_co, alu_cv;
    logic [AW-1:0]    mdst;
    logic [CW-1:0]    cnt;
    state_t           state;

    assign op_a     = rf[cmd_sa];
    assign op_b     = rf[cmd_sb];
    assign dbg_data = rf[dbg_sel];
    assign acc_nx   = acc + (mb[0] ? ma : '0);

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .op  (cmd_op),
        .a   (op_a),
        .b   (op_b),
        .imm (cmd_imm),
        .cin (flag_c),
        .y   (alu_y),
        .co  (alu_co),
        .cv  (alu_cv)
    );

    // command accept, register writeback, flags and the multiply sequencer
    always_ff @(posedge ck or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
            state     <= IDLE;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            res_data  <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            ma        <= '0;
            mb        <= '0;
            acc       <= '0;
            mdst      <= '0;
            cnt       <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    if (cmd_op == OP_MUL) begin
                        ma        <= op_a;
                        mb        <= op_b;
                        mdst      <= cmd_dst;
                        acc       <= '0;
                        cnt       <= CW'(WIDTH);
                        cmd_ready <= 1'b0;
                        state     <= MUL;
                    end else begin
                        rf[cmd_dst] <= alu_y;
                        res_data    <= alu_y;
                        res_valid   <= 1'b1;
                        flag_z      <= (alu_y == '0);
                        flag_c      <= alu_cv ? alu_co : flag_c;
                    end
                end
                MUL: begin
                    acc <= acc_nx;
                    ma  <= ma << 1;
                    mb  <= mb >> 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        rf[mdst]  <= acc_nx;
                        res_data  <= acc_nx;
                        res_valid <= 1'b1;
                        flag_z    <= (acc_nx == '0);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
